instr_decode_stage: RTL
=======================

Name: instr_decode_stage

Overview:
Registered, parametrised decode stage between fetch and execute. It extracts all 32-bit ISA fields, sign- or zero-extends constants to XLEN, flags opcodes disabled by parameter, and forwards the PC. Input and output use valid/ready handshakes through a 2-entry skid buffer, so the stage sustains 1 instr/cycle with fully registered outputs. Supports pipeline flush.

Parameters:
XLEN, 32, width of extended constants constAlu/constAluu/const16; must be >= 32
PC_WIDTH, 27, width of in_pc/out_pc
VALID_OP_MASK, 16'hFFFF, bit n set = opcode n legal

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage accepts this cycle
in_instr  in  32  instruction word
in_pc  in  PC_WIDTH  address of in_instr
flush  in  1  discard all buffered instructions
out_valid  out  1  decoded entry available
out_ready  in  1  execute consumes entry
out_pc  out  PC_WIDTH  PC of output entry
out_instrOP  out  4  instr[31:28]
out_aluOP  out  4  instr[27:24]
out_branchOP  out  3  instr[3:1]
out_constAlu  out  XLEN  instr[23:8], sign-extended
out_constAluu  out  XLEN  instr[23:8], zero-extended
out_const16  out  XLEN  instr[27:12], sign-extended
out_const16u  out  16  instr[27:12]
out_const27  out  27  instr[27:1]
out_areg  out  4  instr[7:4] if op is 0001/0011, else instr[11:8]
out_breg  out  4  0 if op is 0001/0011, else instr[7:4]
out_dreg  out  4  instr[3:0]
out_he  out  1  instr[8]
out_oe  out  1  instr[0]
out_sig  out  1  instr[0]
out_illegal  out  1  VALID_OP_MASK[instr[31:28]] == 0

Behaviour:
- Decode is combinational on in_instr; the result plus in_pc is the entry stored. All out_* come straight from flops.
- Storage: main register (M, drives outputs) and skid register (S). Flags m_valid (= out_valid) and s_valid.
- in_ready = !s_valid && !reset, driven from a flop and the reset gate only; no dependence on out_ready.
- Accept = in_valid && in_ready && !flush. Consume = out_valid && out_ready.
- Entry counts:
  - 0 entries: accept loads M. Latency 1 cycle from accept to out_valid.
  - M only, consume with no accept: M empties.
  - M only, consume and accept: new entry loads M.
  - M only, accept with no consume: entry loads S; in_ready falls next cycle.
  - M and S: consume moves S to M and clears S. No accept is possible in this state.
- Ordering is strict FIFO; nothing is dropped except by flush.
- Throughput: 1/cycle while out_ready is held 1. With out_ready=0, at most 2 entries are held and in_ready=0.
- out_* payload must hold stable while out_valid=1 && out_ready=0.
- Flush has priority over everything:
  - Next cycle m_valid=0 and s_valid=0.
  - An instruction offered in the flush cycle is discarded.
  - A consume in the flush cycle still counts for the downstream side.
- Reset (async assert, any time, including mid-transfer):
  - m_valid, s_valid and all payload flops go to 0; every out_* reads 0.
  - in_ready=0 while reset is high, 1 on the first cycle after release.
- Width rules: sign extension replicates bit 23 (constAlu) or bit 27 (const16) up to XLEN-1. Zero extension fills with 0.

Optional Feature:
INSTR_DECODE_ILLEGAL_TRAP_EN
- Without it: out_illegal is informational; an illegal entry flows like any other.
- With it: extra output trap (1 bit, registered, reset 0). trap=1 on the cycle an entry with out_illegal=1 is consumed.
- After that trap the stage stops accepting (in_ready=0), regardless of buffer state, until a flush cycle.
- Buffered entries after the illegal one are held, not emitted. out_valid goes 0 after the illegal entry is consumed, until flush.

Test Plan:
- Reset, then instr 32'h1FFFF2A5 with out_ready=1 -> one cycle later out_valid=1, out_instrOP=1, out_areg=4'hA, out_breg=0, out_dreg=5, out_constAlu=32'hFFFFFFF2, out_constAluu=32'h0000FFF2.
- XLEN=64, instr 32'h58000000 -> out_const16=64'hFFFFFFFFFFFF8000, out_const16u=16'h8000, out_const27=27'h4000000.
- Stream 8 instrs back-to-back, out_ready=1 -> 8 outputs in order on consecutive cycles, in_ready constantly 1.
- out_ready=0, offer 3 instrs -> first 2 accepted, in_ready=0 from the cycle after the 2nd. Raise out_ready -> the 2 emitted in order, 3rd accepted.
- 2 entries buffered, pulse flush together with in_valid -> next cycle out_valid=0, offered instr never emitted. Assert reset mid-stream -> all outputs 0 immediately.
- VALID_OP_MASK=16'h7FFF, instr 32'hF0000000 -> out_illegal=1. With the macro: trap pulses on consume, in_ready stays 0 until flush.

Source files
------------

// File: rtl/instr_decode_stage.sv
// Registered ISA decode stage between fetch and execute, with a 2-entry skid buffer on valid/ready.
// Optional macro INSTR_DECODE_ILLEGAL_TRAP_EN adds a trap output and halts intake after an illegal entry.
module instr_decode_stage #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned PC_WIDTH      = 27,
    parameter logic [15:0] VALID_OP_MASK = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [3:0]          out_instrOP,
    output logic [3:0]          out_aluOP,
    output logic [2:0]          out_branchOP,
    output logic [XLEN-1:0]     out_constAlu,
    output logic [XLEN-1:0]     out_constAluu,
    output logic [XLEN-1:0]     out_const16,
    output logic [15:0]         out_const16u,
    output logic [26:0]         out_const27,
    output logic [3:0]          out_areg,
    output logic [3:0]          out_breg,
    output logic [3:0]          out_dreg,
    output logic                out_he,
    output logic                out_oe,
    output logic                out_sig,
    output logic                out_illegal
`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                trap
`endif
);

    localparam int unsigned EXT_W = XLEN - 16;
    localparam int unsigned DEC_W = 69 + 3 * XLEN;
    localparam int unsigned ENT_W = PC_WIDTH + DEC_W;

    // Field extraction; the illegal flag sits in bit 0 of the entry.
    function automatic logic [DEC_W-1:0] decode(input logic [31:0] ins);
        logic       one_src;
        logic [3:0] areg;
        logic [3:0] breg;
        one_src = (ins[31:28] == 4'b0001) || (ins[31:28] == 4'b0011);
        areg    = one_src ? ins[7:4] : ins[11:8];
        breg    = one_src ? 4'h0 : ins[7:4];
        return {ins[31:28], ins[27:24], ins[3:1],
                {{EXT_W{ins[23]}}, ins[23:8]},
                {{EXT_W{1'b0}}, ins[23:8]},
                {{EXT_W{ins[27]}}, ins[27:12]},
                ins[27:12], ins[27:1],
                areg, breg, ins[3:0], ins[8], ins[0],
                ~VALID_OP_MASK[ins[31:28]]};
    endfunction

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [ENT_W-1:0] m_q, m_d;
    logic [ENT_W-1:0] s_q, s_d;
    logic             rdy_q, rdy_d;
    logic             accept, consume, take_illegal;
    logic [ENT_W-1:0] new_ent;

    assign in_ready = rdy_q && !reset;
    assign accept   = in_valid && in_ready && !flush;
    assign consume  = m_valid_q && out_ready;
    assign new_ent  = {in_pc, decode(in_instr)};

`ifdef INSTR_DECODE_ILLEGAL_TRAP_EN
    logic halt_q, halt_d;
    logic trap_q;

    assign take_illegal = consume && m_q[0];
    assign halt_d       = !flush && (halt_q || take_illegal);
    assign rdy_d        = !s_valid_d && !halt_d;
    assign trap         = trap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
            trap_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
            trap_q <= take_illegal;
        end
    end
`else
    assign take_illegal = 1'b0;
    assign rdy_d        = !s_valid_d;
`endif

    // Skid-buffer occupancy and data movement; flush wins over everything.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_valid_q && s_valid_q) begin
            if (take_illegal) begin
                m_valid_d = 1'b0;
            end else if (consume) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (m_valid_q) begin
            if (take_illegal) begin
                m_valid_d = 1'b0;
                if (accept) begin
                    s_d       = new_ent;
                    s_valid_d = 1'b1;
                end
            end else if (consume && accept) begin
                m_d = new_ent;
            end else if (consume) begin
                m_valid_d = 1'b0;
            end else if (accept) begin
                s_d       = new_ent;
                s_valid_d = 1'b1;
            end
        end else if (accept) begin
            m_d       = new_ent;
            m_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
            rdy_q     <= 1'b1;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q       <= m_d;
            s_q       <= s_d;
            rdy_q     <= rdy_d;
        end
    end

    assign out_valid = m_valid_q;
    assign {out_pc, out_instrOP, out_aluOP, out_branchOP, out_constAlu, out_constAluu,
            out_const16, out_const16u, out_const27, out_areg, out_breg, out_dreg,
            out_he, out_oe, out_illegal} = m_q;
    assign out_sig = out_oe;

endmodule
